// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the mux4 select and paces beats to one consumer.
// Data never passes through here; only sel/gnt and the valid/ready pacing do.
module mux4_rr_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic          en,
    input  logic          out_ready,
    output logic [1:0]    sel,
    output logic [3:0]    gnt,
    output logic          out_valid,
    output logic          busy,
    output logic [CW-1:0] beat_cnt
);

    // Handshake: a beat is transferred on a rising edge where out_valid and
    // out_ready are both high; out_valid only ever depends on req and state.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;

    logic          in_grant;
    logic          beat;
    logic          release_now;
    logic [1:0]    search_base;
    logic [1:0]    winner;

    // First requester found scanning upward from base, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        pick = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    assign in_grant    = (state_q == GRANT);
    assign out_valid   = in_grant & req[sel_q];
    assign beat        = out_valid & out_ready;
    assign release_now = in_grant & (~req[sel_q] | (beat & (cnt_q == LAST_BEAT)));

    // On release the rotation restarts just past the outgoing owner.
    assign search_base = in_grant ? (sel_q + 2'd1) : ptr_q;
    assign winner      = pick(req, search_base);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (en && (req != 4'b0000)) begin
                        sel_d = winner;
                        gnt_d = 4'b0001 << winner;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign busy     = in_grant;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected beats queued by the driver,
// consumed by an independent beat monitor, plus point checks of grant state.
module tb_mux4_rr_arbiter;

    localparam int W = 14;  // {gnt[3:0], sel[1:0], beat_cnt[7:0]}

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       en;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;
    logic       busy;
    logic [7:0] beat_cnt;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    mux4_rr_arbiter #(.MAX_BEATS(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_beats(input logic [3:0] g, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({g, s, 8'(i)});
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the next queued entry
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got=%0h expected=none", {gnt, sel, beat_cnt});
            end else begin
                e = exp_q.pop_front();
                if ({gnt, sel, beat_cnt} !== e) begin
                    failures++;
                    $display("FAIL beat got=%0h expected=%0h", {gnt, sel, beat_cnt}, e);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        en        = 1'b0;
        out_ready = 1'b0;

        cyc();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_cnt", 32'(beat_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // Single requester: 4 beats, release, immediate re-grant to source 0
        rst_n = 1'b1; req = 4'b0001; en = 1'b1; out_ready = 1'b1;
        cyc();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_sel", 32'(sel), 32'h0);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        push_beats(4'b0001, 2'd0, 4);
        push_beats(4'b0001, 2'd0, 1);
        repeat (5) cyc();
        out_ready = 1'b0;
        check("t1_cnt_after_regrant", 32'(beat_cnt), 32'h1);

        // Async reset between edges while out_valid is high
        #2;
        check("t6_valid_before", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_sel", 32'(sel), 32'h0);
        check("t6_cnt", 32'(beat_cnt), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_valid", 32'(out_valid), 32'h0);
        cyc();
        rst_n = 1'b1; req = 4'b1001; en = 1'b1;
        cyc();
        check("t6_ptr0_gnt", 32'(gnt), 32'h1);
        check("t6_ptr0_sel", 32'(sel), 32'h0);

        // Round robin with all requesting: owners 0,1,2,3,0, 4 beats each
        req = 4'b1111; out_ready = 1'b1;
        push_beats(4'b0001, 2'd0, 4);
        push_beats(4'b0010, 2'd1, 4);
        push_beats(4'b0100, 2'd2, 4);
        push_beats(4'b1000, 2'd3, 4);
        push_beats(4'b0001, 2'd0, 4);
        repeat (20) cyc();
        out_ready = 1'b0;
        check("t2_next_gnt", 32'(gnt), 32'h2);
        check("t2_next_sel", 32'(sel), 32'h1);
        check("t2_next_cnt", 32'(beat_cnt), 32'h0);

        // Backpressure on owner 2
        req = 4'b0101;
        cyc();
        check("t3_gnt", 32'(gnt), 32'h4);
        check("t3_sel", 32'(sel), 32'h2);
        repeat (5) cyc();
        check("t3_hold_cnt", 32'(beat_cnt), 32'h0);
        check("t3_hold_gnt", 32'(gnt), 32'h4);
        check("t3_hold_valid", 32'(out_valid), 32'h1);
        push_beats(4'b0100, 2'd2, 2);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        check("t3_resume_cnt", 32'(beat_cnt), 32'h2);

        // Early release of owner 1 at beat_cnt=1 with req=1001
        req = 4'b0010;
        cyc();
        check("t4_gnt1", 32'(gnt), 32'h2);
        check("t4_cnt0", 32'(beat_cnt), 32'h0);
        push_beats(4'b0010, 2'd1, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0; req = 4'b1001;
        check("t4_cnt1", 32'(beat_cnt), 32'h1);
        cyc();
        check("t4_gnt", 32'(gnt), 32'h8);
        check("t4_sel", 32'(sel), 32'h3);
        check("t4_cnt", 32'(beat_cnt), 32'h0);

        // Enable gating: owner 0 finishes, then idle until en returns
        req = 4'b0011;
        cyc();
        check("t5_gnt0", 32'(gnt), 32'h1);
        en = 1'b0; out_ready = 1'b1;
        push_beats(4'b0001, 2'd0, 4);
        repeat (4) cyc();
        check("t5_idle_gnt", 32'(gnt), 32'h0);
        check("t5_idle_busy", 32'(busy), 32'h0);
        check("t5_idle_valid", 32'(out_valid), 32'h0);
        check("t5_idle_sel", 32'(sel), 32'h0);
        cyc();
        check("t5_still_idle", 32'(gnt), 32'h0);
        en = 1'b1; out_ready = 1'b0;
        cyc();
        check("t5_regrant_gnt", 32'(gnt), 32'h2);
        check("t5_regrant_sel", 32'(sel), 32'h1);

        req = 4'b0000;
        repeat (2) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
